// File: rtl/pipe_addsub_if.sv
// pipe_addsub_if: operation/control inputs and result/flag outputs of pipe_addsub
// master: hazard/control side driving operands, stall and flush
// slave:  the pipelined add/sub unit
interface pipe_addsub_if #(
  parameter int len = 32
) ();
  logic           i_valid;
  logic [len-1:0] i_a;
  logic [len-1:0] i_b;
  logic           i_sub;
  logic           i_stall;
  logic           i_flush;
  logic           o_valid;
  logic [len-1:0] o_result;
  logic           o_carry;
  logic           o_overflow;
  logic           o_zero;
  modport master (
    output i_valid, i_a, i_b, i_sub, i_stall, i_flush,
    input  o_valid, o_result, o_carry, o_overflow, o_zero
  );
  modport slave (
    input  i_valid, i_a, i_b, i_sub, i_stall, i_flush,
    output o_valid, o_result, o_carry, o_overflow, o_zero
  );
endinterface

// File: rtl/pipe_addsub.sv
// pipe_addsub: add/subtract with the carry chain split into `stages` registered segments
// i_clk, i_rst_n (async, active-low); bus: operands, stall/flush in, result and carry/overflow/zero flags out
module pipe_addsub #(
  parameter int len    = 32,
  parameter int stages = 4
) (
  input logic          i_clk,
  input logic          i_rst_n,
  pipe_addsub_if.slave bus
);
  localparam int s_n = stages < 1 ? 1 : stages;
  localparam int seg = len / s_n;
  localparam int l   = s_n - 1;
  if (stages < 1 || len % s_n != 0) begin : g_bad
    $error("pipe_addsub: stages must be >= 1 and divide len");
  end
  logic           adv;
  logic           kill;
  logic           valid_q;
  logic           carry_q;
  logic           overflow_q;
  logic           zero_q;
  logic [len-1:0] result_q;
  assign adv  = ~bus.i_stall;
  assign kill = bus.i_flush;
  // Stage k adds segment k; a_x/b_x keep absolute bit positions so the
  // not-yet-added upper segments shrink by one segment per stage, while
  // r_o grows by one finished result segment per stage.
  for (genvar k = 0; k < s_n; k++) begin : g_st
    logic [len-1:k*seg]     a_x;
    logic [len-1:k*seg]     b_x;
    logic                   c_x;
    logic                   v_x;
    logic [seg:0]           sum;
    logic [(k+1)*seg-1:0]   r_o;
    if (k == 0) begin : g_in
      assign a_x = bus.i_a;
      assign b_x = bus.i_sub ? ~bus.i_b : bus.i_b;
      assign c_x = bus.i_sub;
      assign v_x = bus.i_valid & ~bus.i_stall & ~bus.i_flush;
      assign r_o = sum[seg-1:0];
    end else begin : g_in
      logic [len-1:k*seg] a_q;
      logic [len-1:k*seg] b_q;
      logic [k*seg-1:0]   r_q;
      logic               c_q;
      logic               v_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          a_q <= '0;
          b_q <= '0;
          r_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else begin
          if (kill) v_q <= 1'b0;
          else if (adv) v_q <= g_st[k-1].v_x;
          if (adv) begin
            a_q <= g_st[k-1].a_x[len-1:k*seg];
            b_q <= g_st[k-1].b_x[len-1:k*seg];
            r_q <= g_st[k-1].r_o;
            c_q <= g_st[k-1].sum[seg];
          end
        end
      end
      assign a_x = a_q;
      assign b_x = b_q;
      assign c_x = c_q;
      assign v_x = v_q;
      assign r_o = {sum[seg-1:0], r_q};
    end
    assign sum = {1'b0, a_x[k*seg +: seg]} + {1'b0, b_x[k*seg +: seg]} + {{seg{1'b0}}, c_x};
  end
  // Result and flags only load for a valid operation, so they hold while o_valid=0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      if (kill) valid_q <= 1'b0;
      else if (adv) valid_q <= g_st[l].v_x;
      if (adv && !kill && g_st[l].v_x) begin
        result_q   <= g_st[l].r_o;
        carry_q    <= g_st[l].sum[seg];
        overflow_q <= (g_st[l].a_x[len-1] == g_st[l].b_x[len-1]) && (g_st[l].r_o[len-1] != g_st[l].a_x[len-1]);
        zero_q     <= ~|g_st[l].r_o;
      end
    end
  end
  assign bus.o_valid    = valid_q;
  assign bus.o_result   = result_q;
  assign bus.o_carry    = carry_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_zero     = zero_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed and random checks of pipe_addsub at depths 4, 1 and 32
module tb_pipe_addsub;
  typedef struct packed {logic [31:0] r; logic c; logic o; logic z;} res_t;
  typedef struct packed {logic v; logic [31:0] r; logic c; logic o; logic z;} obs_t;
  typedef struct packed {logic [31:0] a; logic [31:0] b; logic sub; logic [31:0] r; logic c; logic o; logic z;} op_t;
  localparam int dep [3] = '{4, 1, 32};
  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        sub;
  logic        stall;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  int          n_chk;
  int          n_fail;
  int          cyc;
  int          first_cyc;
  int          last_cyc;
  logic        mv [3][32];
  res_t        me [3][32];
  obs_t        obs [3];
  obs_t        outq [$];
  op_t         ops [5];
  pipe_addsub_if #(.len(32)) if4 ();
  pipe_addsub_if #(.len(32)) if1 ();
  pipe_addsub_if #(.len(32)) if32 ();
  assign {if4.i_valid, if4.i_a, if4.i_b, if4.i_sub, if4.i_stall, if4.i_flush} = {valid, a, b, sub, stall, flush};
  assign {if1.i_valid, if1.i_a, if1.i_b, if1.i_sub, if1.i_stall, if1.i_flush} = {valid, a, b, sub, stall, flush};
  assign {if32.i_valid, if32.i_a, if32.i_b, if32.i_sub, if32.i_stall, if32.i_flush} = {valid, a, b, sub, stall, flush};
  assign obs[0] = {if4.o_valid, if4.o_result, if4.o_carry, if4.o_overflow, if4.o_zero};
  assign obs[1] = {if1.o_valid, if1.o_result, if1.o_carry, if1.o_overflow, if1.o_zero};
  assign obs[2] = {if32.o_valid, if32.o_result, if32.o_carry, if32.o_overflow, if32.o_zero};
  pipe_addsub #(.len(32), .stages(4))  u4  (.i_clk(clk), .i_rst_n(rst_n), .bus(if4));
  pipe_addsub #(.len(32), .stages(1))  u1  (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
  pipe_addsub #(.len(32), .stages(32)) u32 (.i_clk(clk), .i_rst_n(rst_n), .bus(if32));
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: true signed/unsigned arithmetic, not the segmented datapath.
  function automatic res_t ref_op(logic [31:0] x, logic [31:0] y, logic s);
    res_t   e;
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint t  = s ? sx - sy : sx + sy;
    e.r = s ? x - y : x + y;
    e.c = s ? (x >= y) : (64'(x) + 64'(y) > 64'hFFFF_FFFF);
    e.o = t != longint'($signed(e.r));
    e.z = e.r == 32'h0;
    return e;
  endfunction

  task automatic model_clear();
    for (int u = 0; u < 3; u++)
      for (int s = 0; s < 32; s++) mv[u][s] = 1'b0;
  endtask

  task automatic tick();
    logic adv0;
    adv0 = rst_n && !stall && !flush;
    if (!rst_n || flush) model_clear();
    else if (!stall)
      for (int u = 0; u < 3; u++) begin
        for (int s = dep[u] - 1; s > 0; s--) begin
          mv[u][s] = mv[u][s-1];
          me[u][s] = me[u][s-1];
        end
        mv[u][0] = valid;
        me[u][0] = ref_op(a, b, sub);
      end
    @(posedge clk);
    #1;
    cyc++;
    for (int u = 0; u < 3; u++) begin
      int t = dep[u] - 1;
      check($sformatf("s%0d_valid", dep[u]), obs[u].v, mv[u][t]);
      if (mv[u][t]) begin
        check($sformatf("s%0d_result", dep[u]), obs[u].r, me[u][t].r);
        check($sformatf("s%0d_carry", dep[u]), obs[u].c, me[u][t].c);
        check($sformatf("s%0d_ovf", dep[u]), obs[u].o, me[u][t].o);
        check($sformatf("s%0d_zero", dep[u]), obs[u].z, me[u][t].z);
      end
    end
    if (adv0 && mv[0][dep[0]-1]) begin
      outq.push_back(obs[0]);
      last_cyc = cyc;
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic put(logic [31:0] x, logic [31:0] y, logic s);
    valid = 1'b1;
    a = x;
    b = y;
    sub = s;
  endtask

  initial begin
    clk = 0; rst_n = 0; valid = 0; sub = 0; stall = 0; flush = 0; a = 0; b = 0;
    n_chk = 0; n_fail = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
    model_clear();
    #1;
    for (int u = 0; u < 3; u++) begin
      check("rst_valid", obs[u].v, 1'b0);
      check("rst_result", obs[u].r, 32'h0);
    end
    #10 rst_n = 1;
    ticks(2);
    put(32'h0000FFFF, 32'h1, 1'b0);
    tick();
    valid = 0;
    ticks(2);
    check("xseg_early", obs[0].v, 1'b0);
    tick();
    check("xseg_valid", obs[0].v, 1'b1);
    check("xseg_result", obs[0].r, 32'h00010000);
    check("xseg_flags", {obs[0].c, obs[0].o, obs[0].z}, 3'b000);
    ticks(34);
    ops[0] = '{32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    ops[1] = '{32'hFFFFFFFF, 32'h1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    ops[2] = '{32'h5,        32'h5, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    ops[3] = '{32'h0,        32'h1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    ops[4] = '{32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    outq.delete();
    for (int i = 0; i < 5; i++) begin
      put(ops[i].a, ops[i].b, ops[i].sub);
      tick();
    end
    valid = 0;
    ticks(36);
    check("dir_count", outq.size(), 5);
    for (int i = 0; i < 5 && i < outq.size(); i++) begin
      check($sformatf("dir%0d_result", i), outq[i].r, ops[i].r);
      check($sformatf("dir%0d_flags", i), {outq[i].c, outq[i].o, outq[i].z}, {ops[i].c, ops[i].o, ops[i].z});
    end
    outq.delete();
    first_cyc = cyc;
    put(1, 1, 0); tick();
    put(2, 2, 0); tick();
    put(3, 3, 0); stall = 1; ticks(2);
    stall = 0; tick();
    put(4, 4, 0); tick();
    valid = 0;
    ticks(36);
    check("stream_count", outq.size(), 4);
    for (int i = 0; i < 4 && i < outq.size(); i++) check($sformatf("stream%0d", i), outq[i].r, 32'(2 * (i + 1)));
    check("stream_span", last_cyc - first_cyc, 9);
    outq.delete();
    put(32'h11, 32'h22, 0); tick();
    put(32'h33, 32'h44, 1); tick();
    put(32'h55, 32'h66, 0); tick();
    valid = 0; flush = 1; stall = 1; tick();
    flush = 0; stall = 0;
    ticks(6);
    check("flush_none", outq.size(), 0);
    put(32'h12345678, 32'h1, 0); tick();
    valid = 0;
    ticks(2);
    check("postflush_early", obs[0].v, 1'b0);
    tick();
    check("postflush_valid", obs[0].v, 1'b1);
    check("postflush_result", obs[0].r, 32'h12345679);
    ticks(34);
    put(32'hA5A5A5A5, 32'h01010101, 0); tick();
    put(32'h00000010, 32'h00000001, 1); tick();
    valid = 0;
    #2 rst_n = 0;
    #1;
    for (int u = 0; u < 3; u++) begin
      check("arst_valid", obs[u].v, 1'b0);
      check("arst_result", obs[u].r, 32'h0);
    end
    tick();
    #2 rst_n = 1;
    outq.delete();
    ticks(36);
    check("arst_lost", outq.size(), 0);
    for (int i = 0; i < 500; i++) begin
      logic [31:0] pick [4];
      pick = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      valid = $urandom_range(0, 3) != 0;
      sub   = $urandom_range(0, 1) == 1;
      a     = $urandom_range(0, 3) == 0 ? pick[$urandom_range(0, 3)] : $urandom;
      b     = $urandom_range(0, 3) == 0 ? pick[$urandom_range(0, 3)] : $urandom;
      stall = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 19) == 0;
      tick();
    end
    valid = 0; stall = 0; flush = 0;
    ticks(36);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
